// File: rtl/r_tile_bank.sv
// One register bank (32 arch regs) plus a 32-slot W queue; requests are acked one cycle after sampling and ignored while committing.
// The queue drains into the arch regs over 32 scan cycles. Define R_TILE_WQ_BYPASS_EN to let reads see pending queue data.
module r_tile_bank #(
  parameter int BANK_ID = 0,
  parameter int DATA_W  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              read_req,
  input  logic              write_req,
  input  logic [6:0]        reg_id,
  input  logic [4:0]        queue_id,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              ack_reg,
  output logic              alignment_err,
  input  logic              commit_req,
  input  logic              flush,
  output logic              commit_done,
  output logic              busy,
  output logic [5:0]        wq_count
);

  typedef enum logic [1:0] {ST_IDLE, ST_COMMIT, ST_DONE} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [4:0]          r_scan;
  logic [DATA_W-1:0]   r_arch   [32];
  logic [31:0]         r_wq_vld;
  logic [4:0]          r_wq_idx [32];
  logic [DATA_W-1:0]   r_wq_dat [32];
  logic [DATA_W-1:0]   r_read_data;
  logic                r_ack;
  logic                r_err;
  logic [5:0]          r_wq_count;

  logic                w_idle;
  logic                w_aligned;
  logic                w_wr_acc;
  logic                w_rd_acc;
  logic                w_wq_wr;
  logic [31:0]         w_vld_nxt;
  logic [5:0]          w_cnt_nxt;
  logic [DATA_W-1:0]   w_rd_val;

  assign w_idle    = (r_state == ST_IDLE);
  assign w_aligned = (reg_id[1:0] == 2'(BANK_ID));
  // A write and a read in the same cycle: the write wins, the read is retried by the initiator.
  assign w_wr_acc  = w_idle & write_req;
  assign w_rd_acc  = w_idle & read_req & ~write_req;
  assign w_wq_wr   = w_wr_acc & w_aligned & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (!flush && commit_req) w_state_nxt = ST_COMMIT;
      ST_COMMIT: if (r_scan == 5'd31)      w_state_nxt = ST_DONE;
      ST_DONE:                             w_state_nxt = ST_IDLE;
      default:                             w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_vld_nxt = r_wq_vld;
    if (w_idle && flush) w_vld_nxt = '0;
    else if (w_wq_wr)    w_vld_nxt[queue_id] = 1'b1;
    if (r_state == ST_DONE) w_vld_nxt = '0;
    w_cnt_nxt = '0;
    for (int i = 0; i < 32; i++) w_cnt_nxt = w_cnt_nxt + 6'(w_vld_nxt[i]);
  end

  always_comb begin
    w_rd_val = r_arch[reg_id[6:2]];
`ifdef R_TILE_WQ_BYPASS_EN
    // Ascending scan so the highest matching slot is the one returned.
    for (int i = 0; i < 32; i++)
      if (r_wq_vld[i] && (r_wq_idx[i] == reg_id[6:2])) w_rd_val = r_wq_dat[i];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) r_arch[i] <= '0;
      r_wq_vld    <= '0;
      r_wq_count  <= '0;
      r_scan      <= '0;
      r_ack       <= 1'b0;
      r_err       <= 1'b0;
      r_read_data <= '0;
    end else begin
      r_wq_vld    <= w_vld_nxt;
      r_wq_count  <= w_cnt_nxt;
      r_ack       <= w_wr_acc | w_rd_acc;
      r_err       <= (w_wr_acc | w_rd_acc) & ~w_aligned;
      r_read_data <= (w_rd_acc && w_aligned) ? w_rd_val : '0;
      if (r_state == ST_COMMIT) begin
        r_scan <= r_scan + 5'd1;
        if (r_wq_vld[r_scan]) r_arch[r_wq_idx[r_scan]] <= r_wq_dat[r_scan];
      end else begin
        r_scan <= '0;
      end
    end
  end

  // Payload needs no reset: it is only consumed behind its valid bit.
  always_ff @(posedge clk) begin
    if (w_wq_wr) begin
      r_wq_idx[queue_id] <= reg_id[6:2];
      r_wq_dat[queue_id] <= write_data;
    end
  end

  assign read_data     = r_read_data;
  assign ack_reg       = r_ack;
  assign alignment_err = r_err;
  assign commit_done   = (r_state == ST_DONE);
  assign busy          = (r_state != ST_IDLE);
  assign wq_count      = r_wq_count;

endmodule

// File: tb/tb_r_tile_bank.sv
// Randomised scoreboard bench for r_tile_bank (BANK_ID=1) against a queue/array reference model.
module tb_r_tile_bank;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        read_req = 1'b0, write_req = 1'b0, commit_req = 1'b0, flush = 1'b0;
  logic [6:0]  reg_id = '0;
  logic [4:0]  queue_id = '0;
  logic [63:0] write_data = '0;
  logic [63:0] read_data;
  logic        ack_reg, alignment_err, commit_done, busy;
  logic [5:0]  wq_count;

  r_tile_bank #(.BANK_ID(1), .DATA_W(64)) dut (
    .clk(clk), .rst_n(rst_n), .read_req(read_req), .write_req(write_req),
    .reg_id(reg_id), .queue_id(queue_id), .write_data(write_data),
    .read_data(read_data), .ack_reg(ack_reg), .alignment_err(alignment_err),
    .commit_req(commit_req), .flush(flush), .commit_done(commit_done),
    .busy(busy), .wq_count(wq_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic [63:0] data;
  } exp_t;

  exp_t        sbq[$];
  int          errors = 0;
  int          checks = 0;
  bit          done = 0;

  logic [63:0] m_arch [32];
  bit          m_vld  [32];
  logic [4:0]  m_idx  [32];
  logic [63:0] m_dat  [32];
  int          m_phase = 0;  // remaining busy cycles; 0 means idle

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(m_vld[i]);
    return n;
  endfunction

  function automatic logic [63:0] ref_read(input logic [6:0] rg);
    logic [63:0] v;
    v = m_arch[rg[6:2]];
`ifdef R_TILE_WQ_BYPASS_EN
    for (int i = 0; i < 32; i++)
      if (m_vld[i] && m_idx[i] == rg[6:2]) v = m_dat[i];
`endif
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_arch[i] = '0;
      m_vld[i]  = 0;
    end
    m_phase = 0;
  endtask

  // Drive one cycle of inputs, let the DUT sample them, then advance the model.
  task automatic cycle(input logic wr, input logic rd, input logic [6:0] rg, input logic [4:0] q,
                       input logic [63:0] d, input logic fl, input logic cm);
    exp_t e;
    bit   al;
    write_req = wr; read_req = rd; reg_id = rg; queue_id = q;
    write_data = d; flush = fl; commit_req = cm;
    @(posedge clk);
    #1;
    al = (rg[1:0] == 2'd1);
    if (m_phase == 0) begin
      if (wr) begin
        e.err = !al; e.data = '0;
        sbq.push_back(e);
        if (al && !fl) begin
          m_vld[q] = 1; m_idx[q] = rg[6:2]; m_dat[q] = d;
        end
      end else if (rd) begin
        e.err = !al; e.data = al ? ref_read(rg) : 64'd0;
        sbq.push_back(e);
      end
      if (fl) begin
        for (int i = 0; i < 32; i++) m_vld[i] = 0;
      end else if (cm) begin
        m_phase = 33;
      end
    end else begin
      m_phase--;
      if (m_phase == 0) begin
        for (int i = 0; i < 32; i++)
          if (m_vld[i]) m_arch[m_idx[i]] = m_dat[i];
        for (int i = 0; i < 32; i++) m_vld[i] = 0;
      end
    end
    chk("busy", busy, 64'(m_phase != 0));
    chk("commit_done", commit_done, 64'(m_phase == 1));
    chk("wq_count", wq_count, 64'(m_count()));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, '0, '0, '0, 0, 0);
  endtask

  // Monitor: every falling edge either consumes one expected ack or requires silence.
  initial begin
    exp_t e;
    while (!done) begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("ack_reg", ack_reg, 64'd1);
        chk("alignment_err", alignment_err, 64'(e.err));
        chk("read_data", read_data, e.data);
      end else begin
        chk("no_ack", ack_reg, 64'd0);
        chk("idle_err", alignment_err, 64'd0);
        chk("idle_read_data", read_data, 64'd0);
      end
    end
  end

  initial begin
    int          r;
    logic        wr, rd, fl, cm;
    logic [6:0]  rg;

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", ack_reg, 64'd0);
    chk("rst_busy", busy, 64'd0);
    chk("rst_done", commit_done, 64'd0);
    chk("rst_count", wq_count, 64'd0);
    chk("rst_data", read_data, 64'd0);
    rst_n = 1'b1;

    // Write then read of reg 5 from slot 3; misaligned reg 6.
    cycle(1, 0, 7'd5, 5'd3, 64'hAA, 0, 0);
    cycle(0, 1, 7'd5, 5'd0, '0, 0, 0);
    cycle(0, 1, 7'd6, 5'd0, '0, 0, 0);
    cycle(1, 0, 7'd6, 5'd4, 64'hBB, 0, 0);
    idle(2);

    // Two writes to reg 5 from different slots, then commit; higher slot must win.
    cycle(1, 0, 7'd5, 5'd2, 64'h11, 0, 0);
    cycle(1, 0, 7'd5, 5'd9, 64'h22, 0, 0);
    cycle(0, 0, '0, '0, '0, 0, 1);
    idle(34);
    cycle(0, 1, 7'd5, 5'd0, '0, 0, 0);

    // Read held through a whole commit, plus write+read collision.
    cycle(1, 1, 7'd9, 5'd7, 64'h1234, 0, 1);
    for (int i = 0; i < 36; i++) cycle(0, 1, 7'd9, 5'd0, '0, 0, 0);

    // Flush discards queued writes before a commit; flush beats commit.
    cycle(1, 0, 7'd13, 5'd0, 64'h5, 0, 0);
    cycle(1, 0, 7'd17, 5'd1, 64'h6, 0, 0);
    cycle(1, 0, 7'd21, 5'd2, 64'h7, 0, 0);
    cycle(1, 0, 7'd25, 5'd3, 64'h8, 1, 1);
    cycle(0, 0, '0, '0, '0, 0, 1);
    idle(34);
    cycle(0, 1, 7'd13, '0, '0, 0, 0);
    cycle(0, 1, 7'd21, '0, '0, 0, 0);

    // Asynchronous reset in the middle of a commit scan.
    cycle(1, 0, 7'd29, 5'd5, 64'hDEAD, 0, 0);
    cycle(0, 0, '0, '0, '0, 0, 1);
    idle(10);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 64'd0);
    chk("mid_rst_done", commit_done, 64'd0);
    chk("mid_rst_count", wq_count, 64'd0);
    chk("mid_rst_ack", ack_reg, 64'd0);
    chk("mid_rst_err", alignment_err, 64'd0);
    chk("mid_rst_data", read_data, 64'd0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    cycle(0, 1, 7'd5, '0, '0, 0, 0);
    cycle(0, 1, 7'd9, '0, '0, 0, 0);
    cycle(0, 1, 7'd29, '0, '0, 0, 0);

    // Randomised traffic, including requests issued while committing.
    for (int n = 0; n < 600; n++) begin
      r  = $urandom_range(0, 99);
      wr = (r < 35);
      rd = (r >= 25 && r < 75);
      fl = (r >= 97);
      cm = (r >= 93);
      if ($urandom_range(0, 3) != 0) rg = {5'($urandom_range(0, 7)), 2'b01};
      else                           rg = 7'($urandom_range(0, 127));
      cycle(wr, rd, rg, 5'($urandom_range(0, 31)), {$urandom, $urandom}, fl, cm);
    end
    idle(40);
    for (int i = 0; i < 8; i++) cycle(0, 1, {5'(i), 2'b01}, '0, '0, 0, 0);
    idle(2);

    chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
    done = 1;
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
